// File: rtl/cache_wb_param_if.sv
// cache_wb_param_if: core word port, memory line port and debug port of the cache
interface cache_wb_param_if #(
    parameter int LINE_WORDS = 4,
    parameter int IDX = 8
);
    logic [31:0]              core_address;
    logic                     core_read;
    logic                     core_write;
    logic [31:0]              core_writedata;
    logic [3:0]               core_byteenable;
    logic                     core_waitrequest;
    logic [31:0]              core_readdata;
    logic [31:0]              mem_address;
    logic                     mem_read;
    logic                     mem_write;
    logic [32*LINE_WORDS-1:0] mem_writedata;
    logic [4*LINE_WORDS-1:0]  mem_byteenable;
    logic                     mem_waitrequest;
    logic [32*LINE_WORDS-1:0] mem_readdata;
    logic [IDX-1:0]           dbg_address;
    logic                     dbg_read;
    logic                     dbg_write;
    logic [31:0]              dbg_writedata;
    logic                     dbg_waitrequest;
    logic [31:0]              dbg_readdata;

    modport master (
        input  core_address, core_read, core_write, core_writedata, core_byteenable,
        output core_waitrequest, core_readdata,
        output mem_address, mem_read, mem_write, mem_writedata, mem_byteenable,
        input  mem_waitrequest, mem_readdata,
        input  dbg_address, dbg_read, dbg_write, dbg_writedata,
        output dbg_waitrequest, dbg_readdata
    );

    modport slave (
        output core_address, core_read, core_write, core_writedata, core_byteenable,
        input  core_waitrequest, core_readdata,
        input  mem_address, mem_read, mem_write, mem_writedata, mem_byteenable,
        output mem_waitrequest, mem_readdata,
        output dbg_address, dbg_read, dbg_write, dbg_writedata,
        input  dbg_waitrequest, dbg_readdata
    );
endinterface

// File: rtl/cache_wb_param.sv
// cache_wb_param: direct-mapped L1 data cache, write-back/allocate or write-through/no-allocate
module cache_wb_param #(
    parameter int LINE_WORDS = 4,
    parameter int SETS = 256,
    parameter int WRITE_BACK = 1
) (
    input logic clk,
    input logic rst_n,
    cache_wb_param_if.master bus_io
);
    localparam int OFS = $clog2(LINE_WORDS) + 2;
    localparam int IDX = $clog2(SETS);
    localparam int TAG = 32 - OFS - IDX;
    localparam int WW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam int LB = 32 * LINE_WORDS;
    localparam int BB = 4 * LINE_WORDS;

    typedef enum logic [2:0] {IDLE, LOOKUP, EVICT, FILL, WTHRU, DBG} state_t;

    state_t          state_q, state_d;
    logic [31:0]     addr_q, addr_d, wdata_q, wdata_d;
    logic [3:0]      be_q, be_d;
    logic            wr_q, wr_d, from_dbg_q, from_dbg_d;
    logic [SETS-1:0] valid_q, valid_d, dirty_q, dirty_d;
    logic [TAG-1:0]  tag_mem [SETS];
    logic [LB-1:0]   data_mem [SETS];

    logic [IDX-1:0]  ri, di, vi;
    logic [TAG-1:0]  rtag;
    logic [WW-1:0]   word;
    logic            hit, fill_we, merge_we;
    logic [LB-1:0]   line, merged;
    logic [31:0]     dbg_status;
    logic            unused_bits;

    assign ri          = addr_q[OFS +: IDX];
    assign rtag        = addr_q[31 -: TAG];
    assign word        = WW'((addr_q >> 2) & 32'(LINE_WORDS - 1));
    assign di          = bus_io.dbg_address;
    assign vi          = from_dbg_q ? di : ri;
    assign line        = data_mem[ri];
    assign hit         = valid_q[ri] && (tag_mem[ri] == rtag);
    assign dbg_status  = valid_q[di] ? {1'b1, dirty_q[di], {(30 - TAG){1'b0}}, tag_mem[di]} : 32'd0;
    assign unused_bits = ^bus_io.dbg_writedata[31:1];

    // Overlay the enabled bytes of the pending write onto the addressed line
    always_comb begin
        merged = line;
        for (int b = 0; b < 4; b++)
            if (be_q[b]) merged[32*int'(word) + 8*b +: 8] = wdata_q[8*b +: 8];
    end

    // Tag/data arrays: filled from memory or updated by write hits, never reset
    always_ff @(posedge clk) begin
        if (fill_we) begin
            data_mem[ri] <= bus_io.mem_readdata;
            tag_mem[ri]  <= rtag;
        end else if (merge_we) begin
            data_mem[ri] <= merged;
        end
    end

    // State, captured request and per-set valid/dirty flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            wr_q       <= 1'b0;
            from_dbg_q <= 1'b0;
            valid_q    <= '0;
            dirty_q    <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            wr_q       <= wr_d;
            from_dbg_q <= from_dbg_d;
            valid_q    <= valid_d;
            dirty_q    <= dirty_d;
        end
    end

    // Next state, flag updates and all bus outputs; outputs follow the state so reset drops them at once
    always_comb begin
        state_d                 = state_q;
        addr_d                  = addr_q;
        wdata_d                 = wdata_q;
        be_d                    = be_q;
        wr_d                    = wr_q;
        from_dbg_d              = from_dbg_q;
        valid_d                 = valid_q;
        dirty_d                 = dirty_q;
        fill_we                 = 1'b0;
        merge_we                = 1'b0;
        bus_io.core_waitrequest = 1'b1;
        bus_io.core_readdata    = '0;
        bus_io.mem_address      = '0;
        bus_io.mem_read         = 1'b0;
        bus_io.mem_write        = 1'b0;
        bus_io.mem_writedata    = '0;
        bus_io.mem_byteenable   = '0;
        bus_io.dbg_waitrequest  = 1'b1;
        bus_io.dbg_readdata     = '0;
        case (state_q)
            IDLE: begin
                if (bus_io.dbg_read || bus_io.dbg_write) begin
                    state_d = DBG;
                end else if (bus_io.core_read || bus_io.core_write) begin
                    state_d    = LOOKUP;
                    addr_d     = bus_io.core_address;
                    wdata_d    = bus_io.core_writedata;
                    be_d       = bus_io.core_byteenable;
                    wr_d       = bus_io.core_write;
                    from_dbg_d = 1'b0;
                end
            end
            LOOKUP: begin
                if (hit && !wr_q) begin
                    bus_io.core_waitrequest = 1'b0;
                    bus_io.core_readdata    = line[32*int'(word) +: 32];
                    state_d                 = IDLE;
                end else if (hit) begin
                    merge_we = 1'b1;
                    if (WRITE_BACK != 0) begin
                        dirty_d[ri]             = 1'b1;
                        bus_io.core_waitrequest = 1'b0;
                        state_d                 = IDLE;
                    end else begin
                        state_d = WTHRU;
                    end
                end else if (wr_q && WRITE_BACK == 0) begin
                    state_d = WTHRU;
                end else begin
                    state_d = dirty_q[ri] ? EVICT : FILL;
                end
            end
            EVICT: begin
                bus_io.mem_write      = 1'b1;
                bus_io.mem_address    = {tag_mem[vi], vi, {OFS{1'b0}}};
                bus_io.mem_writedata  = data_mem[vi];
                bus_io.mem_byteenable = '1;
                if (!bus_io.mem_waitrequest) begin
                    dirty_d[vi] = 1'b0;
                    state_d     = from_dbg_q ? DBG : FILL;
                end
            end
            FILL: begin
                bus_io.mem_read    = 1'b1;
                bus_io.mem_address = {rtag, ri, {OFS{1'b0}}};
                if (!bus_io.mem_waitrequest) begin
                    fill_we     = 1'b1;
                    valid_d[ri] = 1'b1;
                    dirty_d[ri] = 1'b0;
                    state_d     = LOOKUP;
                end
            end
            WTHRU: begin
                bus_io.mem_write      = 1'b1;
                bus_io.mem_address    = {addr_q[31:OFS], {OFS{1'b0}}};
                bus_io.mem_byteenable = BB'(be_q) << (4*int'(word));
                bus_io.mem_writedata  = LB'(wdata_q) << (32*int'(word));
                if (!bus_io.mem_waitrequest) begin
                    bus_io.core_waitrequest = 1'b0;
                    state_d                 = IDLE;
                end
            end
            DBG: begin
                if (bus_io.dbg_read) begin
                    bus_io.dbg_waitrequest = 1'b0;
                    bus_io.dbg_readdata    = dbg_status;
                    state_d                = IDLE;
                end else if (bus_io.dbg_write && bus_io.dbg_writedata[0] && valid_q[di] && dirty_q[di]) begin
                    from_dbg_d = 1'b1;
                    state_d    = EVICT;
                end else begin
                    bus_io.dbg_waitrequest = 1'b0;
                    if (bus_io.dbg_write && bus_io.dbg_writedata[0]) valid_d[di] = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    a_rw_excl: assert property (@(posedge clk) disable iff (!rst_n) !(bus_io.core_read && bus_io.core_write));
endmodule
